// File: rtl/calc_sched_pkg.sv
// Shared definitions for the calculator job scheduler.
// Holds the FSM state encoding, the default idle code of the core's
// one-hot state_out, datapath widths and the latched job payload type.
package calc_sched_pkg;

    localparam int unsigned MODE_W  = 3;
    localparam int unsigned CALC_W  = 32;
    localparam int unsigned STATE_W = 9;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [STATE_W-1:0] DEF_IDLE_STATE = 9'h001;

    // Operands of the job currently (or most recently) handed to the core.
    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [CALC_W-1:0] x;
        logic [CALC_W-1:0] n;
    } calc_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection over NREQ request lines.
// Ports:
//   req_i    - pending request per line
//   ptr_i    - highest-priority line this round
//   gnt_c_o  - one-hot grant (combinational)
//   idx_c_o  - index of the granted line (combinational)
//   any_c_o  - at least one request pending (combinational)
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_c_o,
    output logic [IW-1:0]   idx_c_o,
    output logic            any_c_o
);

    logic [IW:0] pos_c;

    // Scan from ptr_i upward with wrap; first pending line wins.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        pos_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos_c = (IW+1)'(ptr_i) + (IW+1)'(k);
            if (pos_c >= (IW+1)'(NREQ)) begin
                pos_c = pos_c - (IW+1)'(NREQ);
            end
            if (!any_c_o && req_i[pos_c[IW-1:0]]) begin
                any_c_o = 1'b1;
                idx_c_o = pos_c[IW-1:0];
            end
        end
        gnt_c_o[idx_c_o] = any_c_o;
    end

endmodule

// File: rtl/calc_job_scheduler.sv
// Shares one calculator core between NREQ requesters.
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   req_valid/req_ready   - job request / one-cycle accept pulse per requester
//   req_mode/req_x/req_n  - per-requester job operands (flattened slices)
//   rsp_valid/rsp_ready   - one-hot result valid to the owner / owner accept
//   rsp_data/rsp_err      - shared result bus, err = launch or run timeout
//   calc_start/mode/input/n - core launch and operands
//   calc_state/calc_acc   - core one-hot state and accumulator
//   busy                  - scheduler not idle
module calc_job_scheduler
    import calc_sched_pkg::*;
#(
    parameter int unsigned         NREQ       = 4,
    parameter logic [STATE_W-1:0]  IDLE_STATE = DEF_IDLE_STATE,
    parameter int unsigned         LAUNCH_MAX = 8,
    parameter int unsigned         TIMEOUT    = 4095,
    parameter int unsigned         TW         = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [MODE_W*NREQ-1:0]   req_mode,
    input  logic [CALC_W*NREQ-1:0]   req_x,
    input  logic [CALC_W*NREQ-1:0]   req_n,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [CALC_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     calc_start,
    output logic [MODE_W-1:0]        calc_mode,
    output logic [CALC_W-1:0]        calc_input,
    output logic [CALC_W-1:0]        calc_n,
    input  logic [STATE_W-1:0]       calc_state,
    input  logic [CALC_W-1:0]        calc_acc,
    output logic                     busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]        state_q,      state_d;
    logic [TW-1:0]     cnt_q,        cnt_d;
    logic [IW-1:0]     rr_ptr_q,     rr_ptr_d;
    logic [IW-1:0]     owner_q,      owner_d;
    logic [NREQ-1:0]   req_ready_q,  req_ready_d;
    logic [NREQ-1:0]   rsp_valid_q,  rsp_valid_d;
    logic [CALC_W-1:0] rsp_data_q,   rsp_data_d;
    logic              rsp_err_q,    rsp_err_d;
    logic              calc_start_q, calc_start_d;
    calc_job_t         job_q,        job_d;
    logic              busy_q,       busy_d;

    logic [NREQ-1:0]   gnt_c;
    logic [IW-1:0]     gnt_idx_c;
    logic              any_c;
    logic              core_idle_c;
    logic [NREQ-1:0]   owner_oh_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (gnt_c),
        .idx_c_o (gnt_idx_c),
        .any_c_o (any_c)
    );

    assign core_idle_c = (calc_state == IDLE_STATE);

    always_comb begin
        owner_oh_c          = '0;
        owner_oh_c[owner_q] = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            calc_start_q <= 1'b0;
            job_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            calc_start_q <= calc_start_d;
            job_q        <= job_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        req_ready_d  = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        calc_start_d = calc_start_q;
        job_d        = job_q;

        case (state_q)
            S_IDLE: begin
                // A core still busy from an abandoned job blocks new grants.
                if (any_c && core_idle_c) begin
                    req_ready_d  = gnt_c;
                    owner_d      = gnt_idx_c;
                    job_d.mode   = req_mode[gnt_idx_c*MODE_W +: MODE_W];
                    job_d.x      = req_x[gnt_idx_c*CALC_W +: CALC_W];
                    job_d.n      = req_n[gnt_idx_c*CALC_W +: CALC_W];
                    calc_start_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!core_idle_c) begin
                    calc_start_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_RUN;
                end else if (cnt_q == TW'(LAUNCH_MAX - 1)) begin
                    calc_start_d = 1'b0;
                    rsp_err_d    = 1'b1;
                    rsp_data_d   = '0;
                    rsp_valid_d  = owner_oh_c;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (core_idle_c) begin
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = calc_acc;
                    rsp_valid_d = owner_oh_c;
                    state_d     = S_RESP;
                end else if (cnt_q == TW'(TIMEOUT)) begin
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_valid_d = owner_oh_c;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                // rsp_valid_q is one-hot on the owner, masking out other ready bits.
                if (|(rsp_ready & rsp_valid_q)) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign calc_start = calc_start_q;
    assign calc_mode  = job_q.mode;
    assign calc_input = job_q.x;
    assign calc_n     = job_q.n;
    assign busy       = busy_q;

endmodule

// File: doc/calc_job_scheduler.md
Name: calc_job_scheduler

Overview:
Shares one calculator core between NREQ requesters.
- Round-robin arbitration over pending jobs; each job is mode, IEEE-754 single operand and term count n.
- Drives the core's start/mode/calculator_input/n_input and tracks completion through the core's one-hot state_out.
- Captures regacc_out and returns the result to the owning requester over a valid/ready response channel, with a timeout error path.

Parameters:
NREQ, 4, number of requesters (2..8)
IDLE_STATE, 9'h001, one-hot state_out value of the core's idle state
LAUNCH_MAX, 8, cycles allowed for core to leave idle after start
TIMEOUT, 4095, max cycles in RUN before error
TW, 12, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  job pending per requester
req_ready  out  NREQ  one-hot, 1-cycle pulse: job accepted
req_mode  in  3*NREQ  mode per requester, slice i = [3i+2:3i]
req_x  in  32*NREQ  float operand per requester
req_n  in  32*NREQ  term count per requester
rsp_valid  out  NREQ  one-hot result valid to job owner
rsp_ready  in  NREQ  owner accepts result
rsp_data  out  32  result (regacc_out capture), shared bus
rsp_err  out  1  qualifies rsp_valid: 1 = launch/run timeout, rsp_data=0
calc_start  out  1  core start
calc_mode  out  3  core mode
calc_input  out  32  core calculator_input
calc_n  out  32  core n_input
calc_state  in  9  core state_out
calc_acc  in  32  core regacc_out
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM=IDLE; rr_ptr=0; counters 0. Reset mid-job abandons the job and issues no response. The core is reset by the same reset net.
- FSM states: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - If any req_valid, grant g = first index i at or after rr_ptr (wrapping) with req_valid[i]=1.
  - Same cycle: req_ready[g]=1 and latch req_mode/x/n slice g into calc_mode/input/n.
  - Next state LAUNCH, cnt=0.
  - No grant while calc_state != IDLE_STATE.
- LAUNCH:
  - calc_start=1, operands held stable.
  - When calc_state != IDLE_STATE: drop calc_start next cycle, go to RUN, cnt=0.
  - If cnt reaches LAUNCH_MAX-1 without leaving idle: err=1, go to RESP.
- RUN:
  - calc_start=0; cnt increments each cycle.
  - When calc_state == IDLE_STATE: capture calc_acc into rsp_data, err=0, go to RESP.
  - If cnt == TIMEOUT: err=1, rsp_data=0, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP:
  - rsp_valid[g]=1 with rsp_data/rsp_err stable until rsp_ready[g]=1.
  - On that handshake cycle: rsp_valid drops next cycle, rr_ptr = (g+1) mod NREQ, go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Latency, normal job: accept at cycle 0; LAUNCH from 1; RUN entered 1 cycle after core leaves idle; rsp_valid 1 cycle after core returns to idle. Minimum accept-to-next-accept with immediate rsp_ready is core run time + 4 cycles.
- Operand outputs stay at the last job's values in all states (no glitching back to 0).
- req_valid deasserted after grant has no effect. A requester may reassert for a new job while its response is pending; it is only granted after RESP completes.
- Single job in flight; no queueing.

Decomposition:
- Package calc_sched_pkg: state encoding constants (IDLE/LAUNCH/RUN/RESP) and default IDLE_STATE value.
- One sub-module, rr_arbiter (NREQ-wide round-robin, inputs req vector + rr_ptr, outputs one-hot grant + index).

Test Plan:
Benches use a core stub: leaves idle 2 cycles after calc_start, stays busy K cycles, returns acc=calc_input^32'hFFFF0000.
1. Single job, req 0: mode=3'b101, x=32'h3e4ccccd, n=5, K=20, rsp_ready=1 -> req_ready[0] pulse once; calc_start high exactly until stub leaves idle; rsp_valid[0] with rsp_data=32'hc1b3cccd, rsp_err=0.
2. All 4 requesters valid at once from reset -> grant order 0,1,2,3,0; each rsp_valid one-hot to its owner; no overlapping jobs.
3. Backpressure: rsp_ready[1] held 0 for 10 cycles -> rsp_valid[1]/rsp_data stable; no new req_ready until the handshake; rr_ptr then becomes 2.
4. Stub never leaves idle -> after LAUNCH_MAX cycles, rsp_valid with rsp_err=1, rsp_data=0; FSM returns to IDLE.
5. Stub busy K=5000 (> TIMEOUT) -> rsp_err=1 at RUN cycle 4095. Separately, K chosen so completion lands on the timeout cycle -> rsp_err=0.
6. Assert reset during RUN -> all outputs 0 asynchronously; no response issued; a new job after release is accepted from rr_ptr=0.
